fft_in_framer: RTL
==================

FFT_IN_FRAMER -- requirements
Module: fft_in_framer

Interface
REQ-001 Parameter DATA_WIDTH, default 9, sets the sample width of each of R and Q.
REQ-002 Parameter NUM_IN_OUT, default 16, sets the number of parallel lanes per output block.
REQ-003 Parameter FRAME_LEN, default 512, sets the samples per FFT frame; FRAME_LEN/NUM_IN_OUT (32) is the number of blocks per frame.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rstn  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  serial sample strobe; a sample is accepted on each edge with in_valid=1.
REQ-007 in_sof  in  1  start of frame; qualified by in_valid.
REQ-008 in_R, in_Q  in  signed DATA_WIDTH each  serial complex sample.
REQ-009 valid  out  1  block strobe to the FFT first stage.
REQ-010 dout_R, dout_Q  out  signed DATA_WIDTH x [0:NUM_IN_OUT-1]  parallel block.
REQ-011 frame_start  out  1  high with the first block (index 0) of each burst.
REQ-012 frame_err  out  1  sticky; set when a partial frame is discarded.

Function
REQ-013 Two frame banks (0,1) of FRAME_LEN complex samples each; the writer fills one bank while the reader drains the other.
REQ-014 Writer: wr_ptr 0..FRAME_LEN-1; each accepted sample is stored at wr_ptr of the write bank, then wr_ptr increments.
REQ-015 On acceptance at wr_ptr=FRAME_LEN-1: write bank marked full, wr_ptr wraps to 0, write bank toggles.
REQ-016 in_sof=1 with in_valid=1 and wr_ptr!=0: partial frame discarded, sample stored at index 0, wr_ptr=1, frame_err set; with wr_ptr=0, in_sof has no further effect.
REQ-017 in_sof and in_valid=0: ignored.
REQ-018 Reader FSM states IDLE and BURST; IDLE->BURST when any bank is full; BURST->IDLE after block index 31 is emitted, which clears that bank's full flag on the same edge.
REQ-019 In BURST, one block per cycle with no gaps: cycle c (0..31) drives lane k = sample 16c+k of the read bank, valid=1.
REQ-020 frame_start=1 only in cycle c=0 of each burst.
REQ-021 If both banks are full when a burst ends, the next burst starts on the following cycle (oldest bank first); banks are drained in fill order.
REQ-022 Outputs registered: the 512th sample accepted at edge E produces valid=1 and frame_start=1 after edge E+1 (1-cycle fill-to-burst latency).
REQ-023 dout_R/dout_Q SHALL be all-zero whenever valid=0.
REQ-024 Data is passed bit-exact; no scaling, rounding or saturation.
REQ-025 At in_valid duty <= 1 per cycle, a bank is always drained (32 cycles) before refill completes (512 cycles); no input backpressure exists or is required.
REQ-026 A sample written into a bank in the same cycle that bank is read SHALL NOT occur; a bank is never written while full.

Reset
REQ-027 rstn=0 asynchronously: valid=0, frame_start=0, frame_err=0, dout all zero, wr_ptr=0, write bank=0, both full flags clear, FSM=IDLE.
REQ-028 Reset mid-fill or mid-burst discards all buffered data; operation resumes from the first in_valid after rstn rises.
REQ-029 Bank storage contents need not be reset.

Verification
REQ-030 Ramp: 512 consecutive samples in_R=n mod 512 (as signed 9-bit), in_Q=-(n mod 256) -> one cycle after the last, 32 consecutive valid cycles, lane k of cycle c = sample 16c+k, frame_start only on c=0.
REQ-031 Back-to-back: 1024 continuous samples -> two bursts of 32 starting 512 cycles apart, no data loss, second burst carries samples 512..1023.
REQ-032 Gapped: in_valid 1-of-3 cycles for 512 samples -> burst starts exactly one cycle after the 512th accepted sample; valid=0 and dout=0 at all other times.
REQ-033 Resync: in_sof pulse at wr_ptr=100 -> frame_err=1 and stays 1; no burst for the first 100 samples; burst follows the 512th sample counted from the in_sof sample.
REQ-034 Reset during burst cycle c=10 -> valid, frame_start and dout go to 0 immediately; no further blocks; a fresh 512-sample frame then produces a normal burst.
REQ-035 Out of reset, valid=0 for all cycles until a full frame has been accepted.

Source files
------------

// File: rtl/fft_in_framer.sv
// rtl/fft_in_framer.sv - serial-to-parallel ping-pong framer feeding an FFT first stage
//
// Purpose: collects FRAME_LEN serial complex samples into one of two banks and,
// once a bank is full, drains it as FRAME_LEN/NUM_IN_OUT consecutive parallel
// blocks of NUM_IN_OUT lanes while the other bank is being filled.
//
// Ports:
//   clk          sole clock, rising edge
//   rstn         asynchronous active-low reset
//   in_valid     serial sample strobe
//   in_sof       start of frame, qualified by in_valid
//   in_R, in_Q   serial complex sample (signed DATA_WIDTH)
//   valid        block strobe
//   dout_R/Q     parallel block, lane k = sample NUM_IN_OUT*c+k (zero when valid=0)
//   frame_start  high with block 0 of each burst
//   frame_err    sticky, set when a partial frame is discarded by in_sof
module fft_in_framer #(
    parameter int DATA_WIDTH = 9,
    parameter int NUM_IN_OUT = 16,
    parameter int FRAME_LEN  = 512
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         in_valid,
    input  logic                         in_sof,
    input  logic signed [DATA_WIDTH-1:0] in_R,
    input  logic signed [DATA_WIDTH-1:0] in_Q,
    output logic                         valid,
    output logic signed [DATA_WIDTH-1:0] dout_R [0:NUM_IN_OUT-1],
    output logic signed [DATA_WIDTH-1:0] dout_Q [0:NUM_IN_OUT-1],
    output logic                         frame_start,
    output logic                         frame_err
);
    localparam int BLOCKS = FRAME_LEN / NUM_IN_OUT;
    localparam int PTR_W  = $clog2(FRAME_LEN);
    localparam int BLK_W  = $clog2(BLOCKS);
    localparam int LANE_W = $clog2(NUM_IN_OUT);
    localparam int ADDR_W = PTR_W + 1;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    // Both banks share one array; the bank number is the address MSB.
    logic signed [DATA_WIDTH-1:0] mem_R [0:2*FRAME_LEN-1];
    logic signed [DATA_WIDTH-1:0] mem_Q [0:2*FRAME_LEN-1];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, wr_idx;
    logic             wr_bank_q, wr_bank_d;
    logic [1:0]       full_q, full_d;
    logic             set_full, sof_err;
    logic             frame_err_q;

    state_t           state_q;
    logic             rd_bank_q;
    logic [BLK_W-1:0] blk_q, rd_blk;
    logic [ADDR_W-1:0] rd_base;
    logic             last_blk;

    logic signed [DATA_WIDTH-1:0] rd_R [0:NUM_IN_OUT-1];
    logic signed [DATA_WIDTH-1:0] rd_Q [0:NUM_IN_OUT-1];
    logic signed [DATA_WIDTH-1:0] dout_R_q [0:NUM_IN_OUT-1];
    logic signed [DATA_WIDTH-1:0] dout_Q_q [0:NUM_IN_OUT-1];
    logic             valid_q, frame_start_q;

    // Writer next state: an in_sof mid-frame restarts the frame at index 0.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        wr_bank_d = wr_bank_q;
        wr_idx    = wr_ptr_q;
        set_full  = 1'b0;
        sof_err   = 1'b0;
        if (in_valid) begin
            if (in_sof && wr_ptr_q != '0) begin
                wr_idx   = '0;
                wr_ptr_d = PTR_W'(1);
                sof_err  = 1'b1;
            end else if (wr_ptr_q == PTR_W'(FRAME_LEN - 1)) begin
                wr_ptr_d  = '0;
                wr_bank_d = ~wr_bank_q;
                set_full  = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            mem_R[{wr_bank_q, wr_idx}] <= in_R;
            mem_Q[{wr_bank_q, wr_idx}] <= in_Q;
        end
    end

    // Block 0 is fetched while still in IDLE so the burst starts one cycle
    // after the bank fills; BURST then fetches blocks 1..BLOCKS-1.
    always_comb begin
        rd_blk   = (state_q == S_BURST) ? blk_q : '0;
        rd_base  = {rd_bank_q, rd_blk, {LANE_W{1'b0}}};
        last_blk = (state_q == S_BURST) && (blk_q == BLK_W'(BLOCKS - 1));
        for (int k = 0; k < NUM_IN_OUT; k++) begin
            rd_R[k] = mem_R[rd_base + ADDR_W'(k)];
            rd_Q[k] = mem_Q[rd_base + ADDR_W'(k)];
        end
    end

    // The reader only ever drains the bank the writer left earliest, so a
    // single toggling bank pointer keeps fill order.
    always_comb begin
        full_d = full_q;
        if (last_blk) full_d[rd_bank_q] = 1'b0;
        if (set_full) full_d[wr_bank_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q      <= '0;
            wr_bank_q     <= 1'b0;
            full_q        <= '0;
            frame_err_q   <= 1'b0;
            state_q       <= S_IDLE;
            rd_bank_q     <= 1'b0;
            blk_q         <= '0;
            valid_q       <= 1'b0;
            frame_start_q <= 1'b0;
            for (int k = 0; k < NUM_IN_OUT; k++) begin
                dout_R_q[k] <= '0;
                dout_Q_q[k] <= '0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            wr_bank_q <= wr_bank_d;
            full_q    <= full_d;
            if (sof_err) frame_err_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (full_q[rd_bank_q]) begin
                        state_q       <= S_BURST;
                        blk_q         <= BLK_W'(1);
                        valid_q       <= 1'b1;
                        frame_start_q <= 1'b1;
                        dout_R_q      <= rd_R;
                        dout_Q_q      <= rd_Q;
                    end else begin
                        valid_q       <= 1'b0;
                        frame_start_q <= 1'b0;
                        for (int k = 0; k < NUM_IN_OUT; k++) begin
                            dout_R_q[k] <= '0;
                            dout_Q_q[k] <= '0;
                        end
                    end
                end
                default: begin
                    valid_q       <= 1'b1;
                    frame_start_q <= 1'b0;
                    dout_R_q      <= rd_R;
                    dout_Q_q      <= rd_Q;
                    if (last_blk) begin
                        state_q   <= S_IDLE;
                        rd_bank_q <= ~rd_bank_q;
                        blk_q     <= '0;
                    end else begin
                        blk_q <= blk_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign valid       = valid_q;
    assign frame_start = frame_start_q;
    assign frame_err   = frame_err_q;
    assign dout_R      = dout_R_q;
    assign dout_Q      = dout_Q_q;
endmodule
